conv_ctrl: RTL and testbench
============================

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 Parameter DW, 12, signed sample/coefficient width; result width 2*DW.
REQ-002 Parameter K0_INIT, 2, reset value of coefficient 0.
REQ-003 Parameter K1_INIT, 5, reset value of coefficient 1.
REQ-004 Parameter TIMEOUT, 15, max cycles waiting for eng_done (only with CONV_CTRL_TIMEOUT_EN).
REQ-005 clk  in  1  single clock, all logic on posedge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req0_valid/req1_valid  in  1 each  requester has a sample pair.
REQ-008 req0_d0, req0_d1, req1_d0, req1_d1  in  DW each  signed samples.
REQ-009 req0_ready/req1_ready  out  1 each  pair accepted this cycle.
REQ-010 cfg_we  in  1; cfg_sel  in  1 (0=k0, 1=k1); cfg_data  in  DW  coefficient write.
REQ-011 eng_start  out  1; eng_d0, eng_d1, eng_k0, eng_k1  out  DW each  operands to shared 2-tap engine.
REQ-012 eng_done  in  1; eng_res  in  2*DW  engine result (d0*k0 + d1*k1).
REQ-013 res_valid  out  1; res_id  out  1; res_data  out  2*DW; res_err  out  1; res_ready  in  1.
REQ-014 busy  out  1  high whenever state != IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, OUT; IDLE->ISSUE on accept; ISSUE->WAIT always; WAIT->OUT on eng_done (or timeout); OUT->IDLE on res_valid & res_ready.
REQ-016 In IDLE the block SHALL assert exactly one reqN_ready, combinationally, for the granted valid requester; both ready low otherwise and in every other state.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not served last; after reset requester 0 wins.
REQ-018 On accept the block SHALL capture d0, d1, requester id, and snapshot k0, k1 into operand registers.
REQ-019 eng_start SHALL be high for exactly one cycle (state ISSUE); eng_d*/eng_k* SHALL stay stable from ISSUE until leaving WAIT.
REQ-020 eng_done SHALL be ignored outside WAIT; in WAIT the first eng_done captures eng_res into res_data, res_err=0.
REQ-021 Latency: accept at edge T -> eng_start during cycle T+1 -> res_valid high one cycle after the eng_done cycle.
REQ-022 res_valid, res_id, res_data, res_err SHALL hold stable until res_ready; res_ready while res_valid low SHALL be ignored.
REQ-023 cfg_we SHALL update the selected coefficient on any cycle; an in-flight operation SHALL use its snapshot; a write in the accept cycle SHALL NOT affect that operation.
REQ-024 Requester data SHALL not be modified; no result arithmetic in this block (eng_res passed unmodified, sign preserved).

Reset
REQ-025 reset low SHALL asynchronously force IDLE, k0=K0_INIT, k1=K1_INIT, last-served=1, all outputs 0, timeout counter 0.
REQ-026 Reset mid-operation SHALL discard the in-flight pair and result; no res_valid until a new accept completes.
REQ-027 After reset release, first accept SHALL be possible on the first posedge.

Configuration
REQ-028 Macro CONV_CTRL_TIMEOUT_EN defined: counter runs in WAIT; if TIMEOUT cycles pass without eng_done, go to OUT with res_data=0, res_err=1; eng_done in the same cycle as expiry wins (res_err=0).
REQ-029 Macro undefined: no counter, WAIT holds indefinitely, res_err tied 0.

Verification
REQ-030 Reset, req0 d0=3 d1=4, engine model 2-cycle latency -> eng_k0=2 eng_k1=5, res_data=26, res_id=0, res_err=0.
REQ-031 Both valid after reset (req0 1,1; req1 -2,3) -> req0 served first (7), then req1 (11); sustained both-valid -> grants alternate 0,1,0,1.
REQ-032 cfg_we k0=-1 during WAIT of pair (3,4) -> result 26; next pair (3,4) -> 17.
REQ-033 res_ready low 10 cycles in OUT -> res_valid/res_data stable, both ready low, busy=1; res_ready high -> IDLE next cycle.
REQ-034 CONV_CTRL_TIMEOUT_EN, engine never responds -> res_valid after 15 WAIT cycles with res_data=0, res_err=1; without macro -> busy stays 1.
REQ-035 reset pulsed low during WAIT -> outputs 0 immediately, late eng_done ignored, no res_valid.

Source files
------------

// File: rtl/conv_ctrl.sv
// Arbitrating controller feeding a shared 2-tap engine from two requesters.
// Optional wait-for-engine timeout enabled by defining CONV_CTRL_TIMEOUT_EN.
module conv_ctrl #(
    parameter int DW      = 12,
    parameter int K0_INIT = 2,
    parameter int K1_INIT = 5,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic            req1_valid,
    input  logic [DW-1:0]   req0_d0,
    input  logic [DW-1:0]   req0_d1,
    input  logic [DW-1:0]   req1_d0,
    input  logic [DW-1:0]   req1_d1,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic            cfg_we,
    input  logic            cfg_sel,
    input  logic [DW-1:0]   cfg_data,
    output logic            eng_start,
    output logic [DW-1:0]   eng_d0,
    output logic [DW-1:0]   eng_d1,
    output logic [DW-1:0]   eng_k0,
    output logic [DW-1:0]   eng_k1,
    input  logic            eng_done,
    input  logic [2*DW-1:0] eng_res,
    output logic            res_valid,
    output logic            res_id,
    output logic [2*DW-1:0] res_data,
    output logic            res_err,
    input  logic            res_ready,
    output logic            busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]    state;
    logic [DW-1:0] k0, k1;
    logic          last;
    logic          gnt1, accept;

    // Requester 1 wins a tie only when requester 0 was served last.
    assign gnt1       = req1_valid & (~req0_valid | ~last);
    assign req0_ready = (state == S_IDLE) & req0_valid & ~gnt1;
    assign req1_ready = (state == S_IDLE) & gnt1;
    assign accept     = req0_ready | req1_ready;
    assign eng_start  = (state == S_ISSUE);
    assign busy       = (state != S_IDLE);

`ifdef CONV_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
`else
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            k0        <= DW'(K0_INIT);
            k1        <= DW'(K1_INIT);
            last      <= 1'b1;
            eng_d0    <= '0;
            eng_d1    <= '0;
            eng_k0    <= '0;
            eng_k1    <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_data  <= '0;
`ifdef CONV_CTRL_TIMEOUT_EN
            res_err   <= 1'b0;
            tcnt      <= '0;
`endif
        end else begin
            // Operands snapshot the pre-write coefficients, so a same-cycle write misses this op.
            if (cfg_we) begin
                if (cfg_sel) k1 <= cfg_data;
                else         k0 <= cfg_data;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        eng_d0 <= gnt1 ? req1_d0 : req0_d0;
                        eng_d1 <= gnt1 ? req1_d1 : req0_d1;
                        eng_k0 <= k0;
                        eng_k1 <= k1;
                        res_id <= gnt1;
                        last   <= gnt1;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (eng_done) begin
                        res_data  <= eng_res;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
`ifdef CONV_CTRL_TIMEOUT_EN
                        res_err   <= 1'b0;
                        tcnt      <= '0;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        tcnt      <= '0;
                        state     <= S_OUT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
`endif
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_ctrl.sv
// Directed plus randomized bench for conv_ctrl with an abstract coefficient/arbiter model.
// Timeout checks follow CONV_CTRL_TIMEOUT_EN when it is defined for the build.
module tb_conv_ctrl;
    localparam int DW = 12;

    logic clk, reset;
    logic req0_valid, req1_valid, req0_ready, req1_ready;
    logic [DW-1:0] req0_d0, req0_d1, req1_d0, req1_d1;
    logic cfg_we, cfg_sel;
    logic [DW-1:0] cfg_data;
    logic eng_start, eng_done;
    logic [DW-1:0] eng_d0, eng_d1, eng_k0, eng_k1;
    logic [2*DW-1:0] eng_res, res_data;
    logic res_valid, res_id, res_err, res_ready, busy;

    int total = 0, bad = 0;
    int mk0 = 2, mk1 = 5, last = 1;

    conv_ctrl dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_d0(req0_d0), .req0_d1(req0_d1), .req1_d0(req1_d0), .req1_d1(req1_d1),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .eng_start(eng_start), .eng_d0(eng_d0), .eng_d1(eng_d1),
        .eng_k0(eng_k0), .eng_k1(eng_k1), .eng_done(eng_done), .eng_res(eng_res),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .res_err(res_err), .res_ready(res_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rs(input int m);
        return int'($urandom_range(2 * m, 0)) - m;
    endfunction

    // The external engine: computes from whatever operands the DUT presents.
    function automatic logic [2*DW-1:0] eng_calc();
        int p;
        p = int'($signed(eng_d0)) * int'($signed(eng_k0)) + int'($signed(eng_d1)) * int'($signed(eng_k1));
        return p[2*DW-1:0];
    endfunction

    function automatic logic [31:0] r24(input int v);
        logic [31:0] t;
        t = 32'(v);
        return {8'b0, t[23:0]};
    endfunction

    function automatic logic [31:0] r12(input int v);
        logic [31:0] t;
        t = 32'(v);
        return {20'b0, t[11:0]};
    endfunction

    task automatic model_reset;
        mk0 = 2; mk1 = 5; last = 1;
    endtask

    // One full transaction from IDLE. cfg_mode: 0 none, 1 write in accept cycle, 2 write in WAIT.
    task automatic do_op(input bit v0, input bit v1, input int a0, input int a1, input int b0,
                         input int b1, input int lat, input int cfg_mode, input bit csel,
                         input int cdat, input int hold);
        int g, d0, d1, ek0, ek1, exp;
        req0_valid = v0; req0_d0 = DW'(a0); req0_d1 = DW'(a1);
        req1_valid = v1; req1_d0 = DW'(b0); req1_d1 = DW'(b1);
        if (cfg_mode == 1) begin cfg_we = 1'b1; cfg_sel = csel; cfg_data = DW'(cdat); end
        #1;
        g = (v0 && v1) ? (last == 1 ? 0 : 1) : (v1 ? 1 : 0);
        chk("ready0", 32'(req0_ready), 32'(g == 0));
        chk("ready1", 32'(req1_ready), 32'(g == 1));
        chk("idle_busy", 32'(busy), 0);
        d0 = g ? b0 : a0; d1 = g ? b1 : a1;
        ek0 = mk0; ek1 = mk1; last = g;
        exp = d0 * ek0 + d1 * ek1;
        tick;
        req0_valid = 1'b0; req1_valid = 1'b0; cfg_we = 1'b0;
        if (cfg_mode == 1) begin if (csel) mk1 = cdat; else mk0 = cdat; end
        chk("start_hi", 32'(eng_start), 1);
        chk("eng_d0", 32'(eng_d0), r12(d0));
        chk("eng_d1", 32'(eng_d1), r12(d1));
        chk("eng_k0", 32'(eng_k0), r12(ek0));
        chk("eng_k1", 32'(eng_k1), r12(ek1));
        chk("issue_rdy", {30'b0, req0_ready, req1_ready}, 0);
        tick;
        chk("start_lo", 32'(eng_start), 0);
        if (cfg_mode == 2) begin
            cfg_we = 1'b1; cfg_sel = csel; cfg_data = DW'(cdat);
            tick;
            cfg_we = 1'b0;
            if (csel) mk1 = cdat; else mk0 = cdat;
        end
        for (int i = 1; i < lat; i++) tick;
        chk("wait_k0", 32'(eng_k0), r12(ek0));
        chk("wait_d1", 32'(eng_d1), r12(d1));
        chk("wait_valid", 32'(res_valid), 0);
        eng_done = 1'b1; eng_res = eng_calc();
        tick;
        eng_done = 1'b0; eng_res = 24'($urandom);
        chk("res_valid", 32'(res_valid), 1);
        chk("res_data", {8'b0, res_data}, r24(exp));
        chk("res_id", 32'(res_id), 32'(g));
        chk("res_err", 32'(res_err), 0);
        for (int i = 0; i < hold; i++) begin
            eng_done = 1'b1;
            tick;
            eng_done = 1'b0;
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_data", {8'b0, res_data}, r24(exp));
            chk("hold_busy", 32'(busy), 1);
            req0_valid = 1'b1; req1_valid = 1'b1; #1;
            chk("hold_rdy", {30'b0, req0_ready, req1_ready}, 0);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("done_valid", 32'(res_valid), 0);
        chk("done_busy", 32'(busy), 0);
    endtask

    task automatic pulse_reset;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int v0, v1;
        reset = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_d0 = 0; req0_d1 = 0; req1_d0 = 0; req1_d1 = 0;
        cfg_we = 0; cfg_sel = 0; cfg_data = 0; eng_done = 0; eng_res = 0; res_ready = 0;
        tick; tick;
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(eng_start), 0);
        chk("rst_k0", 32'(eng_k0), 0);
        chk("rst_data", {8'b0, res_data}, 0);
        reset = 1'b1;

        // Basic pair, then in-flight coefficient write, then held output.
        do_op(1, 0, 3, 4, 0, 0, 2, 0, 0, 0, 0);
        chk("req030_val", {8'b0, res_data}, r24(26));
        do_op(1, 0, 3, 4, 0, 0, 2, 2, 0, -1, 0);
        do_op(1, 0, 3, 4, 0, 0, 2, 0, 0, 0, 0);
        chk("req032_val", {8'b0, res_data}, r24(17));
        do_op(0, 1, 7, 8, -5, 6, 3, 0, 0, 0, 10);

        // Round-robin from reset with both requesters valid.
        pulse_reset();
        do_op(1, 1, 1, 1, -2, 3, 1, 0, 0, 0, 0);
        chk("rr_first", {8'b0, res_data}, r24(7));
        do_op(1, 1, 1, 1, -2, 3, 1, 0, 0, 0, 0);
        chk("rr_second", {8'b0, res_data}, r24(11));
        do_op(1, 1, 1, 1, -2, 3, 1, 0, 0, 0, 0);
        do_op(1, 1, 1, 1, -2, 3, 1, 1, 1, 9, 0);

        for (int n = 0; n < 40; n++) begin
            v0 = int'($urandom_range(1, 0));
            v1 = v0 ? int'($urandom_range(1, 0)) : 1;
            do_op(bit'(v0), bit'(v1), rs(1000), rs(1000), rs(1000), rs(1000),
                  int'($urandom_range(4, 1)), int'($urandom_range(2, 0)),
                  bit'($urandom_range(1, 0)), rs(100), int'($urandom_range(2, 0)));
        end

        // Stray handshake/engine pulses while idle must do nothing.
        res_ready = 1'b1; eng_done = 1'b1; tick; tick;
        res_ready = 1'b0; eng_done = 1'b0;
        chk("idle_stray_valid", 32'(res_valid), 0);
        chk("idle_stray_busy", 32'(busy), 0);

        // Engine that never answers.
        req0_valid = 1'b1; req0_d0 = 12'd3; req0_d1 = 12'd4;
        tick; req0_valid = 1'b0; last = 0;
        tick;
`ifdef CONV_CTRL_TIMEOUT_EN
        for (int i = 0; i < 14; i++) tick;
        chk("to_before", 32'(res_valid), 0);
        tick;
        chk("to_valid", 32'(res_valid), 1);
        chk("to_data", {8'b0, res_data}, 0);
        chk("to_err", 32'(res_err), 1);
        res_ready = 1'b1; tick; res_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick; req0_valid = 1'b0; req1_valid = 1'b0; last = 1;
        tick;
        for (int i = 0; i < 14; i++) tick;
        eng_done = 1'b1; eng_res = 24'h123456;
        tick; eng_done = 1'b0;
        chk("to_race_err", 32'(res_err), 0);
        chk("to_race_data", {8'b0, res_data}, 32'h123456);
        chk("to_race_id", 32'(res_id), 1);
        res_ready = 1'b1; tick; res_ready = 1'b0;
`else
        for (int i = 0; i < 40; i++) tick;
        chk("hang_busy", 32'(busy), 1);
        chk("hang_valid", 32'(res_valid), 0);
        chk("hang_err", 32'(res_err), 0);
        pulse_reset();
`endif

        // Reset pulsed during WAIT discards the operation.
        do_op(1, 0, 2, 2, 0, 0, 1, 1, 0, 50, 0);
        req1_valid = 1'b1; req1_d0 = 12'd5; req1_d1 = 12'd6;
        tick; req1_valid = 1'b0;
        tick;
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_start", 32'(eng_start), 0);
        chk("arst_d0", 32'(eng_d0), 0);
        chk("arst_k0", 32'(eng_k0), 0);
        chk("arst_valid", 32'(res_valid), 0);
        tick;
        reset = 1'b1; model_reset();
        eng_done = 1'b1; eng_res = 24'hABCDEF;
        tick; eng_done = 1'b0;
        tick;
        chk("late_done_valid", 32'(res_valid), 0);
        chk("late_done_busy", 32'(busy), 0);
        do_op(1, 1, 5, 6, 1, 1, 2, 0, 0, 0, 1);
        chk("post_rst_val", {8'b0, res_data}, r24(40));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
